// File: rtl/branch_cmp_if.sv
// Operand/opcode request and registered compare result bundle for branch_cmp.
// The pipeline drives the request side; the comparator drives the result side.
interface branch_cmp_if #(
   parameter int XLEN = 32
);
   logic            i_valid;
   logic [XLEN-1:0] i_a;
   logic [XLEN-1:0] i_b;
   logic [2:0]      i_cmpop;
   logic            o_valid;
   logic            o_taken;
   logic            o_illegal;
   logic            o_eq;
   logic            o_lt;
   logic            o_ltu;

   modport master (
      output i_valid, i_a, i_b, i_cmpop,
      input  o_valid, o_taken, o_illegal, o_eq, o_lt, o_ltu
   );

   modport slave (
      input  i_valid, i_a, i_b, i_cmpop,
      output o_valid, o_taken, o_illegal, o_eq, o_lt, o_ltu
   );
endinterface

// File: rtl/branch_cmp.sv
// Branch-condition comparator for the execute stage: RISC-V funct3 opcodes,
// one-cycle registered result with valid qualifier and raw eq/lt/ltu flags.
module branch_cmp #(
   parameter int XLEN = 32
) (
   input logic        i_clk,
   input logic        i_rst_n,
   branch_cmp_if.slave bus
);

   localparam logic [2:0] OP_BEQ  = 3'b000;
   localparam logic [2:0] OP_BNE  = 3'b001;
   localparam logic [2:0] OP_BLT  = 3'b100;
   localparam logic [2:0] OP_BGE  = 3'b101;
   localparam logic [2:0] OP_BLTU = 3'b110;
   localparam logic [2:0] OP_BGEU = 3'b111;

   logic eq;
   logic ltu;
   logic lt;
   logic low_ltu;
   logic sign_a;
   logic sign_b;
   logic taken;
   logic illegal;

   // Signed order reuses the unsigned compare of the bits below the MSB;
   // only a sign mismatch overrides it.
   always_comb begin
      sign_a  = bus.i_a[XLEN-1];
      sign_b  = bus.i_b[XLEN-1];
      eq      = (bus.i_a == bus.i_b);
      ltu     = (bus.i_a < bus.i_b);
      low_ltu = (bus.i_a[XLEN-2:0] < bus.i_b[XLEN-2:0]);
      lt      = (sign_a != sign_b) ? sign_a : low_ltu;
   end

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (bus.i_cmpop)
         OP_BEQ:  taken = eq;
         OP_BNE:  taken = !eq;
         OP_BLT:  taken = lt;
         OP_BGE:  taken = !lt;
         OP_BLTU: taken = ltu;
         OP_BGEU: taken = !ltu;
         default: illegal = 1'b1;
      endcase
   end

   // o_valid depends only on i_valid so idle-cycle garbage on the operands
   // never reaches it; the result fields simply hold while idle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bus.o_valid   <= 1'b0;
         bus.o_taken   <= 1'b0;
         bus.o_illegal <= 1'b0;
         bus.o_eq      <= 1'b0;
         bus.o_lt      <= 1'b0;
         bus.o_ltu     <= 1'b0;
      end else begin
         bus.o_valid <= bus.i_valid;
         if (bus.i_valid) begin
            bus.o_taken   <= taken;
            bus.o_illegal <= illegal;
            bus.o_eq      <= eq;
            bus.o_lt      <= lt;
            bus.o_ltu     <= ltu;
         end
      end
   end

endmodule

// File: tb/tb_branch_cmp.sv
// Self-checking bench for branch_cmp: directed cases from the plan followed by
// randomized traffic compared against a plain-arithmetic reference model.
module tb_branch_cmp;

   localparam int XLEN = 32;

   logic clk;
   logic rst_n;
   int   check_count;
   int   error_count;

   branch_cmp_if #(.XLEN(XLEN)) bus ();

   branch_cmp #(.XLEN(XLEN)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference: {taken, illegal, eq, lt, ltu} straight from the opcode table.
   function automatic logic [4:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
      logic eq_r, lt_r, ltu_r, taken_r, illegal_r;
      eq_r      = (a == b);
      lt_r      = ($signed(a) < $signed(b));
      ltu_r     = (a < b);
      illegal_r = (op == 3'd2) || (op == 3'd3);
      case (op)
         3'd0:    taken_r = eq_r;
         3'd1:    taken_r = !eq_r;
         3'd4:    taken_r = lt_r;
         3'd5:    taken_r = !lt_r;
         3'd6:    taken_r = ltu_r;
         3'd7:    taken_r = !ltu_r;
         default: taken_r = 1'b0;
      endcase
      return {taken_r, illegal_r, eq_r, lt_r, ltu_r};
   endfunction

   // Drives one cycle of input and checks the registered result after the edge.
   task automatic applyStimulus(input string tag, input logic valid, input logic [31:0] a,
                                input logic [31:0] b, input logic [2:0] op);
      logic [4:0] exp_v;
      @(negedge clk);
      bus.i_valid = valid;
      if (valid) begin
         bus.i_a     = a;
         bus.i_b     = b;
         bus.i_cmpop = op;
      end else begin
         bus.i_a     = 'x;
         bus.i_b     = 'x;
         bus.i_cmpop = 'x;
      end
      @(posedge clk);
      #1;
      checkOutput({tag, ".valid"}, 32'(bus.o_valid), 32'(valid));
      if (valid) begin
         exp_v = refModel(a, b, op);
         checkOutput({tag, ".taken"},   32'(bus.o_taken),   32'(exp_v[4]));
         checkOutput({tag, ".illegal"}, 32'(bus.o_illegal), 32'(exp_v[3]));
         checkOutput({tag, ".eq"},      32'(bus.o_eq),      32'(exp_v[2]));
         checkOutput({tag, ".lt"},      32'(bus.o_lt),      32'(exp_v[1]));
         checkOutput({tag, ".ltu"},     32'(bus.o_ltu),     32'(exp_v[0]));
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".valid"},   32'(bus.o_valid),   32'd0);
      checkOutput({tag, ".taken"},   32'(bus.o_taken),   32'd0);
      checkOutput({tag, ".illegal"}, 32'(bus.o_illegal), 32'd0);
      checkOutput({tag, ".eq"},      32'(bus.o_eq),      32'd0);
      checkOutput({tag, ".lt"},      32'(bus.o_lt),      32'd0);
      checkOutput({tag, ".ltu"},     32'(bus.o_ltu),     32'd0);
   endtask

   function automatic logic [31:0] pickOperand();
      logic [31:0] corners [6];
      corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   initial begin
      logic [31:0] ra, rb;
      check_count = 0;
      error_count = 0;
      rst_n       = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_a     = '0;
      bus.i_b     = '0;
      bus.i_cmpop = '0;

      #3 rst_n = 1'b0;
      #1 checkAllZero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("beq_eq",  1'b1, 32'd3, 32'd3, 3'b000);
      applyStimulus("beq_ne",  1'b1, 32'd5, 32'd3, 3'b000);
      applyStimulus("bne_eq",  1'b1, 32'd3, 32'd3, 3'b001);
      applyStimulus("bne_ne",  1'b1, 32'd5, 32'd3, 3'b001);

      applyStimulus("blt_m1",  1'b1, 32'hFFFF_FFFF, 32'd1, 3'b100);
      applyStimulus("bltu_m1", 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b110);
      applyStimulus("bge_m1",  1'b1, 32'hFFFF_FFFF, 32'd1, 3'b101);
      applyStimulus("bgeu_m1", 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b111);

      applyStimulus("blt_min",  1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 3'b100);
      applyStimulus("bltu_min", 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 3'b110);
      applyStimulus("bge_zero",  1'b1, 32'd0, 32'd0, 3'b101);
      applyStimulus("bgeu_zero", 1'b1, 32'd0, 32'd0, 3'b111);
      applyStimulus("blt_zero",  1'b1, 32'd0, 32'd0, 3'b100);

      applyStimulus("rsv_010", 1'b1, 32'd7, 32'd7, 3'b010);
      applyStimulus("rsv_011", 1'b1, 32'd7, 32'd7, 3'b011);

      applyStimulus("stream0", 1'b1, 32'd1, 32'd1, 3'b000);
      applyStimulus("stream1", 1'b1, 32'd1, 32'd1, 3'b001);
      applyStimulus("stream2", 1'b1, 32'd0, 32'd1, 3'b110);
      applyStimulus("gap",     1'b0, 32'd0, 32'd0, 3'b000);
      applyStimulus("resume",  1'b1, 32'd9, 32'd2, 3'b101);

      // Asynchronous reset between edges while a result is on the outputs.
      applyStimulus("pre_rst", 1'b1, 32'd4, 32'd4, 3'b000);
      #2 rst_n = 1'b0;
      #1 checkAllZero("async_rst");
      @(negedge clk);
      bus.i_valid = 1'b0;
      rst_n = 1'b1;
      applyStimulus("post_rst0", 1'b0, 32'd0, 32'd0, 3'b000);
      applyStimulus("post_rst1", 1'b0, 32'd0, 32'd0, 3'b000);
      applyStimulus("post_rst_v", 1'b1, 32'hFFFF_FFFE, 32'd2, 3'b100);

      for (int i = 0; i < 300; i++) begin
         ra = pickOperand();
         rb = ($urandom_range(0, 4) == 0) ? ra : pickOperand();
         applyStimulus("rand", ($urandom_range(0, 3) != 0), ra, rb, 3'($urandom_range(0, 7)));
      end

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
